// File: rtl/fc_input_loader.sv
// Stream-to-vector loader: packs IN signed words from a valid/ready stream into x[0:IN-1].
// Define FC_LOADER_DBUF_EN for ping-pong buffering; default build is single-buffer FILL/HOLD.
module fc_input_loader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IN    = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [WIDTH-1:0] x [0:IN-1],
  output logic             x_valid,
  input  logic             x_ready,
  output logic             frame_err
);

  localparam int unsigned CW = (IN > 1) ? $clog2(IN) : 1;
  localparam logic [CW-1:0] LastIdx = CW'(IN - 1);

  localparam logic [1:0] FILL  = 2'd0;
`ifdef FC_LOADER_DBUF_EN
  localparam logic [1:0] STALL = 2'd2;
`else
  localparam logic [1:0] HOLD  = 2'd1;
`endif

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          x_valid_q, x_valid_d;
  logic          frame_err_q;
  logic          accept, last_word;

  // Reset gates the handshake outputs so a held frame vanishes in the reset cycle itself.
  assign s_ready   = !rst && (state_q == FILL);
  assign x_valid   = x_valid_q && !rst;
  assign frame_err = frame_err_q && !rst;
  assign accept    = s_valid && s_ready;
  assign last_word = (cnt_q == LastIdx);

`ifdef FC_LOADER_DBUF_EN
  logic [WIDTH-1:0] fbuf [0:IN-1];
  logic             copy;

  always_comb begin
    state_d   = state_q;
    x_valid_d = x_valid_q;
    copy      = 1'b0;
    unique case (state_q)
      FILL: begin
        if (x_valid_q && x_ready) x_valid_d = 1'b0;
        if (accept && last_word) begin
          if (!x_valid_q || x_ready) begin
            copy      = 1'b1;
            x_valid_d = 1'b1;
          end else begin
            state_d = STALL;
          end
        end
      end
      STALL: begin
        if (x_ready) begin
          copy      = 1'b1;
          x_valid_d = 1'b1;
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end
`else
  always_comb begin
    state_d   = state_q;
    x_valid_d = x_valid_q;
    unique case (state_q)
      FILL: begin
        if (accept && last_word) begin
          state_d   = HOLD;
          x_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (x_ready) begin
          state_d   = FILL;
          x_valid_d = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      x_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      for (int k = 0; k < IN; k++) x[k] <= '0;
`ifdef FC_LOADER_DBUF_EN
      for (int k = 0; k < IN; k++) fbuf[k] <= '0;
`endif
    end else begin
      state_q     <= state_d;
      x_valid_q   <= x_valid_d;
      // Counting is authoritative; s_last only feeds the error flag.
      frame_err_q <= accept && (s_last != last_word);
      if (accept) cnt_q <= last_word ? '0 : cnt_q + CW'(1);
`ifdef FC_LOADER_DBUF_EN
      if (accept) fbuf[cnt_q] <= s_data;
      if (copy) begin
        for (int k = 0; k < IN; k++) x[k] <= fbuf[k];
        // The completing word has not reached fbuf yet; bypass it straight into x.
        if (accept) x[IN-1] <= s_data;
      end
`else
      if (accept) x[cnt_q] <= s_data;
`endif
    end
  end

endmodule
